// File: rtl/branch_resolve_unit.sv
// Branch resolver: keeps the {S,Z,C,V} flag register and evaluates a branch request one cycle after its handshake.
// A taken branch holds the request channel closed and raises flush for FLUSH_CYCLES cycles after the result pulse.
module branch_resolve_unit #(
    parameter int PC_W         = 16,
    parameter int DISP_W       = 12,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        flag_in,
    input  logic              flag_we,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [3:0]        br_cond,
    input  logic [PC_W-1:0]   br_pc,
    input  logic [DISP_W-1:0] br_disp,
    output logic              res_valid,
    output logic              res_taken,
    output logic [PC_W-1:0]   res_pc,
    output logic              flush,
    output logic [3:0]        flags
);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES);
    localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESOLVE  = 2'd1,
        FLUSH_ST = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       eval_flags;
    logic             cond_true;
    logic             xfer;
    logic [PC_W-1:0]  disp_ext;
    logic [PC_W-1:0]  fall_pc;
    logic [PC_W-1:0]  targ_pc;

    assign br_ready  = (state == IDLE);
    assign res_valid = (state == RESOLVE);
    assign flush     = (state == FLUSH_ST);
    assign xfer      = br_valid & br_ready;

    // A flag write in the same cycle as the handshake is seen by the condition.
    assign eval_flags = flag_we ? flag_in : flags;

    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            4'b0000: cond_true = eval_flags[2];
            4'b0001: cond_true = ~eval_flags[2];
            4'b0010: cond_true = eval_flags[3] ^ eval_flags[0];
            4'b0011: cond_true = ~(eval_flags[3] ^ eval_flags[0]);
            4'b0100: cond_true = eval_flags[2] | (eval_flags[3] ^ eval_flags[0]);
            4'b0101: cond_true = ~eval_flags[2] & ~(eval_flags[3] ^ eval_flags[0]);
            4'b0110: cond_true = eval_flags[1];
            4'b0111: cond_true = ~eval_flags[1];
            4'b1000: cond_true = eval_flags[3];
            4'b1001: cond_true = ~eval_flags[3];
            4'b1010: cond_true = eval_flags[0];
            4'b1011: cond_true = ~eval_flags[0];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign disp_ext = PC_W'($signed(br_disp));
    assign fall_pc  = br_pc + PC_ONE;
    assign targ_pc  = fall_pc + disp_ext;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (xfer) state_nxt = RESOLVE;
            end
            RESOLVE: begin
                if (res_taken) begin
                    state_nxt = FLUSH_ST;
                    cnt_nxt   = CNT_INIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            FLUSH_ST: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            flags     <= 4'b0000;
            res_taken <= 1'b0;
            res_pc    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (flag_we) flags <= flag_in;
            if (xfer) begin
                res_taken <= cond_true;
                res_pc    <= cond_true ? targ_pc : fall_pc;
            end
        end
    end
endmodule
